ms_uart_rx: RTL and testbench
=============================

Name: ms_uart_rx

Overview:
Serial receive engine for the APB UART. It sits between the RX pin and the RX FIFO write port. It oversamples RX at 16x the baud rate, frames 8N1 characters and emits one write pulse per good character. Framing errors are reported separately so the register block can raise status and interrupts.

Parameters:
DW, 8, data bits per character (LSB first)
PW, 16, prescale register width
OS, 16, oversampling ticks per bit (fixed; power of two)

Ports:
PCLK  input  1  system clock
PRESETn  input  1  asynchronous active-low reset
en  input  1  UART enable AND RX enable from CTRL
prescale  input  PW  tick period minus one, in PCLK cycles
rx  input  1  raw serial input (asynchronous to PCLK)
data  output  DW  received character; valid when wr pulses
wr  output  1  one-cycle pulse, pushes data into RX FIFO
frame_err  output  1  one-cycle pulse, stop bit sampled low
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock (PCLK); reset is asynchronous and active-low (PRESETn).
- Reset values: data=0, wr=0, frame_err=0, busy=0, state=IDLE, sync flops=1, counters=0.
- Synchronizer: rx passes through 2 flops (rx_s). The edge detector uses a third flop (rx_d).
- Tick generator:
  - Down-counter reloads with prescale; tick=1 for one cycle when the count reaches 0.
  - Tick rate = PCLK/(prescale+1); baud = PCLK/((prescale+1)*OS).
  - prescale=0 gives a tick every cycle.
  - Runs only while en=1; held at reload otherwise.
  - A prescale change takes effect at the next reload.
- Sampling:
  - sample_cnt counts 0..OS-1 per bit, advancing on ticks.
  - Samples are taken at ticks 7, 8 and 9; the bit value is the majority of the three.
  - The bit decision is made at tick 9.
- FSM:
  - IDLE: on a falling edge (rx_d=1, rx_s=0) with en=1, go to START and clear sample_cnt. A low level without an edge is ignored, so a stuck-low line never retriggers.
  - START: at the tick-9 decision, a majority of 0 is a valid start and sets sample_cnt to re-align, so the data bits are sampled mid-bit. A majority of 1 is a false start: go to IDLE with no pulse.
  - DATA: one bit per OS ticks; shift right into shreg with the MSB entering first position, giving LSB-first reception. After DW bits go to STOP.
  - STOP: at the decision, 1 gives data<=shreg and wr=1 for one cycle; 0 gives frame_err=1 for one cycle, wr stays 0 and data is unchanged. Either way go to IDLE.
- Latency: wr asserts in the cycle after the stop-bit tick 9, i.e. about (1+DW)*OS+9 ticks after the start edge plus 3 PCLK cycles of synchronizer/edge delay.
- en deasserted in any state: immediate IDLE; the partial frame is discarded, no wr or frame_err is issued, and the tick counter is held.
- wr and frame_err are never high together. Neither depends on FIFO state: the RX FIFO owns overflow handling.
- Back-to-back frames: the next start edge is accepted from IDLE the cycle after the STOP decision. The half stop bit remaining after the decision is tolerated.
- Reset mid-frame: all state is cleared asynchronously, with no output pulse.

Decomposition:
- Package ms_uart_pkg holds:
  - FSM state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - Constants OS=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9.
  - Default widths DW and PW.
- Sub-module ms_uart_tick_gen (prescale down-counter, ports PCLK, PRESETn, en, prescale, tick) is shared with the future TX engine.

Test Plan:
- Basic receive, prescale=2 (48 PCLK per bit): drive 0x55 8N1 → exactly one wr pulse with data=0x55, frame_err=0, busy low after.
- Loopback sequence: 0x11,0x22,…,0x88 back-to-back → 8 wr pulses in order with matching data and no gaps lost.
- Framing error: 0xA5 with stop bit driven low → frame_err pulses once, wr=0, data retains the previous value; after rx returns high, the next 0x3C is received correctly.
- Glitch: rx low for 20 PCLK cycles (under half a bit at prescale=2) → false start, return to IDLE, no wr/frame_err. Also a single-tick spike inside a data bit is rejected by the majority vote, e.g. 0x00 with one 3-cycle high spike at tick 8 of bit 3 still gives data=0x00.
- Enable/reset abort: deassert en during bit 4 of 0xF0 → busy drops the next cycle with no pulses; re-enable and send 0x0F → data=0x0F. Repeat with PRESETn low mid-frame → all outputs 0 asynchronously.
- Prescale extremes: prescale=0 and prescale=16'hFFFF (shortened with force) → 0xC3 received correctly; a prescale change between frames applies from the next frame.

Source files
------------

// File: rtl/ms_uart_pkg.sv
// ms_uart_pkg: shared types, constants and helpers for the UART serial engines
package ms_uart_pkg;
   localparam int DW = 8;
   localparam int PW = 16;
   localparam int OS = 16;
   localparam int SAMPLE_LO = 7;
   localparam int SAMPLE_MID = 8;
   localparam int SAMPLE_HI = 9;
   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} rx_state_t;
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
endpackage

// File: rtl/ms_uart_tick_gen.sv
// ms_uart_tick_gen: prescale down-counter producing one oversampling tick per prescale+1 cycles
module ms_uart_tick_gen #(
   parameter int PW = 16
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          en,
   input  logic [PW-1:0] prescale,
   output logic          tick
);
   logic [PW-1:0] cnt;
   assign tick = en && cnt == '0;
   // count down while enabled, reload on expiry, park at the reload value while disabled
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) cnt <= '0;
      else cnt <= (!en || tick) ? prescale : cnt - 1'b1;
endmodule

// File: rtl/ms_uart_rx.sv
// ms_uart_rx: 16x oversampling 8N1 receive engine feeding the RX FIFO write port
module ms_uart_rx #(
   parameter int DW = ms_uart_pkg::DW,
   parameter int PW = ms_uart_pkg::PW,
   parameter int OS = ms_uart_pkg::OS
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          en,
   input  logic [PW-1:0] prescale,
   input  logic          rx,
   output logic [DW-1:0] data,
   output logic          wr,
   output logic          frame_err,
   output logic          busy
);
   import ms_uart_pkg::*;
   localparam int SW = $clog2(OS);
   localparam int BW = $clog2(DW);
   logic rx_m, rx_s, rx_d, tick, fall, dec, bit_val, s_lo, s_mid, wr_nxt, err_nxt;
   logic [SW-1:0] sample_cnt;
   logic [BW-1:0] bit_cnt;
   logic [DW-1:0] shreg;
   rx_state_t state, state_nxt;

   ms_uart_tick_gen #(.PW(PW)) u_tick (
      .PCLK(PCLK), .PRESETn(PRESETn), .en(en), .prescale(prescale), .tick(tick)
   );

   assign fall = rx_d & ~rx_s;
   assign dec = tick && sample_cnt == SW'(SAMPLE_HI);
   assign bit_val = maj3(s_lo, s_mid, rx_s);

   // two-flop synchronizer plus a delay flop for falling-edge detection; idle line is high
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) {rx_m, rx_s, rx_d} <= '1;
      else {rx_m, rx_s, rx_d} <= {rx, rx_m, rx_s};

   // FSM state register
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) state <= IDLE;
      else state <= state_nxt;

   // next state: only a fresh falling edge starts a frame, disable aborts from anywhere
   always_comb begin
      state_nxt = state;
      if (!en) state_nxt = IDLE;
      else
         case (state)
            IDLE:    if (fall) state_nxt = START;
            START:   if (dec) state_nxt = bit_val ? IDLE : DATA;
            DATA:    if (dec && bit_cnt == BW'(DW - 1)) state_nxt = STOP;
            default: if (dec) state_nxt = IDLE;
         endcase
   end

   // outputs: stop-bit decision selects between a write and a framing error
   always_comb begin
      busy = state != IDLE;
      wr_nxt = state == STOP && dec && bit_val;
      err_nxt = state == STOP && dec && !bit_val;
   end

   // sample counter, majority samples, shift register and registered output pulses
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         sample_cnt <= '0;
         bit_cnt <= '0;
         shreg <= '0;
         s_lo <= 1'b1;
         s_mid <= 1'b1;
         data <= '0;
         wr <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         wr <= wr_nxt;
         frame_err <= err_nxt;
         if (wr_nxt) data <= shreg;
         if (state == IDLE) begin
            bit_cnt <= '0;
            if (fall) sample_cnt <= '0;
         end else if (tick) begin
            sample_cnt <= (state == START && dec) ? SW'(SAMPLE_HI + 1) : sample_cnt + 1'b1;
            if (sample_cnt == SW'(SAMPLE_LO)) s_lo <= rx_s;
            if (sample_cnt == SW'(SAMPLE_MID)) s_mid <= rx_s;
            if (state == DATA && dec) begin
               shreg <= {bit_val, shreg[DW-1:1]};
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_ms_uart_rx.sv
// tb_ms_uart_rx: scoreboard bench for the UART receive engine
module tb_ms_uart_rx;
   logic PCLK = 1'b0, PRESETn = 1'b1, en = 1'b0, rx = 1'b1;
   logic [15:0] prescale = 16'd2;
   logic [7:0] data;
   logic wr, frame_err, busy;
   int n_chk = 0, n_fail = 0, wr_cnt = 0, ferr_cnt = 0, t, w0, f0;
   logic [7:0] exp_q[$];
   logic [8:0] e;

   ms_uart_rx dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .en(en), .prescale(prescale), .rx(rx),
      .data(data), .wr(wr), .frame_err(frame_err), .busy(busy)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop = 1'b1, input int spike = -1);
      int bp, h;
      bp = (int'(prescale) + 1) * 16;
      h = (int'(prescale) + 1) * 8;
      if (stop) exp_q.push_back(b);
      rx = 1'b0;
      cyc(bp);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == spike) begin
            cyc(h);
            rx = 1'b1;
            cyc(3);
            rx = b[i];
            cyc(bp - h - 3);
         end else cyc(bp);
      end
      rx = stop;
      cyc(bp);
      rx = 1'b1;
   endtask

   // scoreboard: every write pulse pops one expected character
   always @(negedge PCLK) begin
      if (wr || frame_err) check("wr_ferr_excl", wr & frame_err, 0);
      if (frame_err) ferr_cnt++;
      if (wr) begin
         wr_cnt++;
         e = exp_q.size() != 0 ? {1'b0, exp_q.pop_front()} : 9'h100;
         check("wr_data", {24'd0, data}, {23'd0, e});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #1 PRESETn = 1'b0;
      #20;
      check("rst_data", data, 0);
      check("rst_wr", wr, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_busy", busy, 0);
      PRESETn = 1'b1;
      cyc(3);
      en = 1'b1;
      cyc(5);
      send(8'h55);
      check("basic_q", exp_q.size(), 0);
      check("basic_cnt", wr_cnt, 1);
      check("basic_ferr", ferr_cnt, 0);
      check("basic_busy", busy, 0);
      for (int i = 1; i <= 8; i++) send(8'(i * 8'h11));
      check("loop_cnt", wr_cnt, 9);
      check("loop_q", exp_q.size(), 0);
      cyc(20);
      send(8'hA5, 1'b0);
      check("ferr_cnt", ferr_cnt, 1);
      check("ferr_nowr", wr_cnt, 9);
      check("ferr_data_kept", data, 8'h88);
      cyc(100);
      send(8'h3C);
      check("after_ferr", data, 8'h3C);
      check("after_ferr_cnt", wr_cnt, 10);
      cyc(20);
      rx = 1'b0;
      cyc(10);
      check("glitch_busy", busy, 1);
      cyc(10);
      rx = 1'b1;
      cyc(150);
      check("glitch_idle", busy, 0);
      check("glitch_wr", wr_cnt, 10);
      check("glitch_ferr", ferr_cnt, 1);
      send(8'h00, 1'b1, 3);
      check("spike_data", data, 8'h00);
      check("spike_cnt", wr_cnt, 11);
      cyc(20);
      rx = 1'b0;
      cyc(48);
      for (int i = 0; i < 4; i++) cyc(48);
      rx = 1'b1;
      cyc(24);
      check("abort_busy_before", busy, 1);
      w0 = wr_cnt;
      f0 = ferr_cnt;
      en = 1'b0;
      cyc(1);
      check("abort_busy_drop", busy, 0);
      cyc(300);
      check("abort_wr", wr_cnt, w0);
      check("abort_ferr", ferr_cnt, f0);
      en = 1'b1;
      cyc(10);
      send(8'h0F);
      check("abort_recover", data, 8'h0F);
      cyc(20);
      rx = 1'b0;
      cyc(48 * 3);
      rx = 1'b1;
      cyc(10);
      check("rst_mid_busy_before", busy, 1);
      PRESETn = 1'b0;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_data", data, 0);
      check("rst_mid_wr", wr, 0);
      check("rst_mid_ferr", frame_err, 0);
      cyc(5);
      PRESETn = 1'b1;
      cyc(400);
      check("rst_mid_nopulse", wr_cnt, w0 + 1);
      send(8'h55);
      check("rst_recover", data, 8'h55);
      prescale = 16'hFFFF;
      t = 0;
      while (dut.tick !== 1'b1 && t < 20) begin
         cyc(1);
         t++;
      end
      check("ffff_tick_seen", dut.tick, 1);
      cyc(1);
      check("ffff_reload", dut.u_tick.cnt, 16'hFFFF);
      cyc(5);
      check("ffff_count", dut.u_tick.cnt, 16'hFFFA);
      force dut.u_tick.cnt = 16'd0;
      #1;
      check("ffff_forced_tick", dut.tick, 1);
      release dut.u_tick.cnt;
      en = 1'b0;
      cyc(1);
      check("ffff_park", dut.u_tick.cnt, 16'hFFFF);
      prescale = 16'd0;
      cyc(1);
      en = 1'b1;
      cyc(5);
      send(8'hC3);
      check("ps0_data", data, 8'hC3);
      cyc(10);
      prescale = 16'd1;
      cyc(5);
      send(8'h5A);
      check("ps1_data", data, 8'h5A);
      cyc(20);
      check("final_q", exp_q.size(), 0);
      check("final_wr", wr_cnt, w0 + 4);
      check("final_ferr", ferr_cnt, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
